// File: rtl/param_stack_if.sv
// Operand-stack port bundle: the control unit drives ops and data, the stack returns TOS/NOS and status.
interface param_stack_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
);
    logic             enable;
    logic             push;
    logic             pop;
    logic             pop_alu;
    logic             clear_err;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output enable, push, pop, pop_alu, clear_err, data_in,
        input  tos, nos, count, empty, full, overflow, underflow
    );

    modport slave (
        input  enable, push, pop, pop_alu, clear_err, data_in,
        output tos, nos, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/param_stack.sv
// Parametrised LIFO operand stack with TOS/NOS visibility, replace-top and ALU pop-two/push-one ops,
// and sticky overflow/underflow flags.
module param_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input logic        clock,
    input logic        reset,
    param_stack_if.slave bus
);
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;
    logic             underflow_r;

    logic [CNT_W-1:0] next_count_s;
    logic [AW-1:0]    cnt_lo_s;
    logic [AW-1:0]    wr_addr_s;
    logic             wr_en_s;
    logic             ovf_set_s;
    logic             unf_set_s;
    logic             empty_s;
    logic             full_s;
    logic             lt2_s;

    // Entry indices wrap modulo 2^AW; count never exceeds DEPTH so count-1/count-2 stay in range.
    assign cnt_lo_s = count_r[AW-1:0];
    assign empty_s  = (count_r == CNT_W'(0));
    assign full_s   = (count_r == CNT_W'(DEPTH));
    assign lt2_s    = (count_r < CNT_W'(2));

    // Op decode: next count, storage write and error-set requests (pop_alu overrides pop).
    always_comb begin
        next_count_s = count_r;
        wr_en_s      = 1'b0;
        wr_addr_s    = cnt_lo_s;
        ovf_set_s    = 1'b0;
        unf_set_s    = 1'b0;
        case ({bus.pop_alu, bus.push, bus.pop})
            3'b010: begin
                if (full_s) begin
                    ovf_set_s = 1'b1;
                end else begin
                    wr_en_s      = 1'b1;
                    wr_addr_s    = cnt_lo_s;
                    next_count_s = count_r + CNT_W'(1);
                end
            end
            3'b001: begin
                if (empty_s) begin
                    unf_set_s = 1'b1;
                end else begin
                    next_count_s = count_r - CNT_W'(1);
                end
            end
            3'b011: begin
                if (empty_s) begin
                    wr_en_s      = 1'b1;
                    wr_addr_s    = cnt_lo_s;
                    next_count_s = count_r + CNT_W'(1);
                end else begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = cnt_lo_s - AW'(1);
                end
            end
            3'b100, 3'b101: begin
                if (lt2_s) begin
                    unf_set_s = 1'b1;
                end else begin
                    next_count_s = count_r - CNT_W'(2);
                end
            end
            3'b110, 3'b111: begin
                if (lt2_s) begin
                    unf_set_s = 1'b1;
                end else begin
                    wr_en_s      = 1'b1;
                    wr_addr_s    = cnt_lo_s - AW'(2);
                    next_count_s = count_r - CNT_W'(1);
                end
            end
            default: begin
                next_count_s = count_r;
            end
        endcase
    end

    // Storage has no reset; stale words are hidden by the count qualification on the read side.
    always_ff @(posedge clock) begin
        if (bus.enable && wr_en_s) begin
            mem_r[wr_addr_s] <= bus.data_in;
        end
    end

    // Stack pointer and sticky error flags; a new error wins over clear_err in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r     <= CNT_W'(0);
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (bus.enable) begin
            count_r     <= next_count_s;
            overflow_r  <= ovf_set_s | (overflow_r & ~bus.clear_err);
            underflow_r <= unf_set_s | (underflow_r & ~bus.clear_err);
        end else begin
            count_r     <= count_r;
            overflow_r  <= overflow_r;
            underflow_r <= underflow_r;
        end
    end

    assign bus.tos       = empty_s ? {WIDTH{1'b0}} : mem_r[cnt_lo_s - AW'(1)];
    assign bus.nos       = lt2_s   ? {WIDTH{1'b0}} : mem_r[cnt_lo_s - AW'(2)];
    assign bus.count     = count_r;
    assign bus.empty     = empty_s;
    assign bus.full      = full_s;
    assign bus.overflow  = overflow_r;
    assign bus.underflow = underflow_r;
endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack (DEPTH=4): directed vector table, queue-model random run, async reset.
module tb_param_stack;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic clock;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    param_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        en, pu, po, pa, cl;
        logic [31:0] d;
        int          c;
        logic [31:0] t, n;
        logic        o, u;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] q[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(logic en, logic pu, logic po, logic pa, logic cl, logic [31:0] d,
                                int c, logic [31:0] t, logic [31:0] n, logic o, logic u);
        vec_t v;
        v.en = en; v.pu = pu; v.po = po; v.pa = pa; v.cl = cl; v.d = d;
        v.c = c; v.t = t; v.n = n; v.o = o; v.u = u;
        return v;
    endfunction

    // Reference: stack as a queue whose last element is the top.
    task automatic model_step(input logic en, input logic pu, input logic po, input logic pa,
                              input logic cl, input logic [31:0] d);
        logic eo, eu;
        eo = 1'b0; eu = 1'b0;
        if (en) begin
            if (pa) begin
                if (q.size() < 2) eu = 1'b1;
                else if (pu) begin void'(q.pop_back()); q[q.size()-1] = d; end
                else begin void'(q.pop_back()); void'(q.pop_back()); end
            end else if (pu && po) begin
                if (q.size() == 0) q.push_back(d);
                else q[q.size()-1] = d;
            end else if (pu) begin
                if (q.size() == DEPTH) eo = 1'b1;
                else q.push_back(d);
            end else if (po) begin
                if (q.size() == 0) eu = 1'b1;
                else void'(q.pop_back());
            end
            m_ovf = eo | (m_ovf & ~cl);
            m_unf = eu | (m_unf & ~cl);
        end
    endtask

    task automatic apply(input logic en, input logic pu, input logic po, input logic pa,
                         input logic cl, input logic [31:0] d);
        @(negedge clock);
        bus.enable = en; bus.push = pu; bus.pop = po; bus.pop_alu = pa;
        bus.clear_err = cl; bus.data_in = d;
        model_step(en, pu, po, pa, cl, d);
        @(posedge clock);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] et, en_;
        et  = (q.size() > 0) ? q[q.size()-1] : 32'd0;
        en_ = (q.size() > 1) ? q[q.size()-2] : 32'd0;
        check({tag, " count"}, 32'(bus.count), 32'(q.size()));
        check({tag, " tos"}, bus.tos, et);
        check({tag, " nos"}, bus.nos, en_);
        check({tag, " flags"}, {28'd0, bus.empty, bus.full, bus.overflow, bus.underflow},
              {28'd0, q.size() == 0, q.size() == DEPTH, m_ovf, m_unf});
    endtask

    initial begin
        reset = 1'b0;
        bus.enable = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.pop_alu = 1'b0;
        bus.clear_err = 1'b0; bus.data_in = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        check("reset count", 32'(bus.count), 32'd0);
        check("reset tos/nos", bus.tos | bus.nos, 32'd0);
        check("reset empty/full", {30'd0, bus.empty, bus.full}, 32'd2);
        check("reset flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        //          en   pu   po   pa   cl   data          cnt tos           nos           o    u
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,1'b0,32'hAAAA0000, 1,32'hAAAA0000,32'h0,       1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,1'b0,32'hBBBB0000, 2,32'hBBBB0000,32'hAAAA0000,1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,1'b0,32'hCCCC0000, 3,32'hCCCC0000,32'hBBBB0000,1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,1'b0,32'hDDDD0000, 4,32'hDDDD0000,32'hCCCC0000,1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,1'b0,32'hEEEE0000, 4,32'hDDDD0000,32'hCCCC0000,1'b1,1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        3,32'hCCCC0000,32'hBBBB0000,1'b1,1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        2,32'hBBBB0000,32'hAAAA0000,1'b1,1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        1,32'hAAAA0000,32'h0,       1'b1,1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        0,32'h0,       32'h0,       1'b1,1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        0,32'h0,       32'h0,       1'b1,1'b1));
        tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b1,32'h0,        0,32'h0,       32'h0,       1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,1'b0,32'd5,        1,32'd5,       32'h0,       1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,1'b0,32'd7,        2,32'd7,       32'd5,       1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b1,1'b0,32'd12,       1,32'd12,      32'h0,       1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b0,32'h0,        1,32'd12,      32'h0,       1'b0,1'b1));
        tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b1,32'h0,        1,32'd12,      32'h0,       1'b0,1'b1));
        tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b1,32'h0,        1,32'd12,      32'h0,       1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        0,32'h0,       32'h0,       1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,1'b1,1'b0,1'b0,32'd1,        1,32'd1,       32'h0,       1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,1'b1,1'b0,1'b0,32'd9,        1,32'd9,       32'h0,       1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'd3,        1,32'd9,       32'h0,       1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,1'b0,32'd2,        2,32'd2,       32'd9,       1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b1,1'b1,1'b0,32'h0,        0,32'h0,       32'h0,       1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,1'b0,32'd3,        1,32'd3,       32'h0,       1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,1'b0,32'd4,        2,32'd4,       32'd3,       1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,1'b0,32'd5,        3,32'd5,       32'd4,       1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,1'b0,32'd6,        4,32'd6,       32'd5,       1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,1'b1,1'b0,1'b0,32'd77,       4,32'd77,      32'd5,       1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,1'b1,32'd8,        4,32'd77,      32'd5,       1'b1,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,        4,32'd77,      32'd5,       1'b1,1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b1,32'h0,        4,32'd77,      32'd5,       1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b0,32'h0,        2,32'd4,       32'd3,       1'b0,1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].en, tbl[i].pu, tbl[i].po, tbl[i].pa, tbl[i].cl, tbl[i].d);
            check($sformatf("vec%0d count", i), 32'(bus.count), 32'(tbl[i].c));
            check($sformatf("vec%0d tos", i), bus.tos, tbl[i].t);
            check($sformatf("vec%0d nos", i), bus.nos, tbl[i].n);
            check($sformatf("vec%0d flags", i),
                  {28'd0, bus.empty, bus.full, bus.overflow, bus.underflow},
                  {28'd0, tbl[i].c == 0, tbl[i].c == DEPTH, tbl[i].o, tbl[i].u});
        end

        for (int k = 0; k < 600; k++) begin
            apply($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, $urandom);
            check_model($sformatf("rnd%0d", k));
        end

        // Async reset while a push is being presented, sampled between clock edges.
        for (int k = 0; k < DEPTH + 1; k++) apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000 + k);
        check_model("prefill");
        @(negedge clock);
        bus.push = 1'b1; bus.data_in = 32'h5A5A5A5A;
        #2;
        reset = 1'b0;
        #1;
        check("midreset count", 32'(bus.count), 32'd0);
        check("midreset tos/nos", bus.tos | bus.nos, 32'd0);
        check("midreset status", {28'd0, bus.empty, bus.full, bus.overflow, bus.underflow}, 32'h8);
        @(posedge clock);
        #1;
        check("midreset hold", 32'(bus.count), 32'd0);
        bus.push = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
